srt4_io_sequencer: RTL

Handshake adapter wrapped around the SRT radix-4 divider core (begin/inbus/outbus/end byte protocol). It accepts a 16-bit dividend and an 8-bit divisor over valid/ready and serialises them onto the core's 8-bit input bus. It then waits for the core's end strobe, collects remainder and quotient from the 8-bit output bus, and presents them downstream over valid/ready. Divide-by-zero and quotient overflow are detected locally and bypass the core. A watchdog flags a hung core.

---
 rtl/srt4_pkg.sv | 18 +
 rtl/srt4_watchdog.sv | 38 +++
 rtl/srt4_io_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/srt4_pkg.sv
// Shared types and constants for the SRT radix-4 divider I/O sequencer.
package srt4_pkg;

   localparam int                BYTE_W             = 8;
   localparam logic [BYTE_W-1:0] DIV_SENTINEL       = 8'hFF;
   localparam int                DEF_TIMEOUT_CYCLES = 64;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_HI,
      ST_LOAD_LO,
      ST_LOAD_B,
      ST_WAIT,
      ST_READ_Q,
      ST_DONE
   } state_e;

endpackage

// File: rtl/srt4_watchdog.sv
// Cycle counter that measures how long the divider core has been silent.
module srt4_watchdog
   import srt4_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int CNT_W          = 7
) (
   input  logic clk,
   input  logic rst_b,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // NOTE: next-state logic assigns its default first so no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // NOTE: registers update with non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/srt4_io_sequencer.sv
// Valid/ready front end for the SRT radix-4 divider core: streams operands in,
// collects remainder/quotient, and short-circuits divide-by-zero and overflow.
module srt4_io_sequencer
   import srt4_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int CNT_W          = 7
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       dividend,
   input  logic [BYTE_W-1:0] divisor,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [BYTE_W-1:0] quotient,
   output logic [BYTE_W-1:0] remainder,
   output logic              div_by_zero,
   output logic              overflow,
   output logic              timeout,
   output logic              div_begin,
   output logic [BYTE_W-1:0] div_inbus,
   input  logic [BYTE_W-1:0] div_outbus,
   input  logic              div_end
);

   state_e            state_q, state_d;
   logic [15:0]       dividend_q, dividend_d;
   logic [BYTE_W-1:0] divisor_q, divisor_d;
   logic [BYTE_W-1:0] quotient_q, quotient_d;
   logic [BYTE_W-1:0] remainder_q, remainder_d;
   logic              dbz_q, dbz_d;
   logic              ovf_q, ovf_d;
   logic              tmo_q, tmo_d;
   logic              in_ready_q, in_ready_d;
   logic              wd_clr, wd_en, wd_expired;

   srt4_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .CNT_W         (CNT_W)
   ) u_watchdog (
      .clk      (clk),
      .rst_b    (rst_b),
      .clr_i    (wd_clr),
      .en_i     (wd_en),
      .expired_o(wd_expired)
   );

   always_comb begin
      state_d     = state_q;
      dividend_d  = dividend_q;
      divisor_d   = divisor_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
      ovf_d       = ovf_q;
      tmo_d       = tmo_q;
      wd_clr      = 1'b0;
      wd_en       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready_q) begin
               dividend_d = dividend;
               divisor_d  = divisor;
               dbz_d      = 1'b0;
               ovf_d      = 1'b0;
               tmo_d      = 1'b0;
               // Quotient fits in a byte only when the high dividend byte is below the divisor.
               if (divisor == '0) begin
                  dbz_d       = 1'b1;
                  quotient_d  = DIV_SENTINEL;
                  remainder_d = dividend[7:0];
                  state_d     = ST_DONE;
               end else if (dividend[15:8] >= divisor) begin
                  ovf_d       = 1'b1;
                  quotient_d  = DIV_SENTINEL;
                  remainder_d = '0;
                  state_d     = ST_DONE;
               end else begin
                  state_d = ST_LOAD_HI;
               end
            end
         end
         ST_LOAD_HI: state_d = ST_LOAD_LO;
         ST_LOAD_LO: state_d = ST_LOAD_B;
         ST_LOAD_B: begin
            wd_clr  = 1'b1;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            wd_en = 1'b1;
            if (div_end) begin
               remainder_d = div_outbus;
               state_d     = ST_READ_Q;
            end else if (wd_expired) begin
               tmo_d       = 1'b1;
               quotient_d  = '0;
               remainder_d = '0;
               state_d     = ST_DONE;
            end
         end
         ST_READ_Q: begin
            quotient_d = div_outbus;
            state_d    = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      in_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q     <= ST_IDLE;
         dividend_q  <= '0;
         divisor_q   <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
         ovf_q       <= 1'b0;
         tmo_q       <= 1'b0;
         in_ready_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         dividend_q  <= dividend_d;
         divisor_q   <= divisor_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
         ovf_q       <= ovf_d;
         tmo_q       <= tmo_d;
         in_ready_q  <= in_ready_d;
      end
   end

   always_comb begin
      div_inbus = '0;
      case (state_q)
         ST_LOAD_HI: div_inbus = dividend_q[15:8];
         ST_LOAD_LO: div_inbus = dividend_q[7:0];
         ST_LOAD_B:  div_inbus = divisor_q;
         default:    div_inbus = '0;
      endcase
   end

   assign div_begin   = (state_q == ST_LOAD_HI);
   assign out_valid   = (state_q == ST_DONE);
   assign in_ready    = in_ready_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;
   assign overflow    = ovf_q;
   assign timeout     = tmo_q;

endmodule
